// File: rtl/mste_speed_seq_if.sv
// Mega STE speed sequencer signal bundle.
//
// Groups the config-register requests, CPU bus status, cache controller
// handshake and CPU clock-enable/status outputs of mste_speed_seq.
//   master : the sequencer side (drives clken, effective speed/cache, flush, hold)
//   slave  : the environment side (drives requests, address strobe, flush ack)
//
// Signals:
//   req_16mhz       requested speed (1 = 16 MHz)
//   req_cache       requested cache enable
//   cpu_as_n        CPU address strobe, high = bus idle
//   cache_flush_ack cache controller flush complete (level)
//   cpu_clken       one-clk CPU clock-enable pulse
//   speed_16        effective speed currently applied
//   cache_en        effective cache enable currently applied
//   cache_flush     flush request to the cache controller (level)
//   cpu_hold        high while a change is in progress
//   flush_timeout   sticky flush-timeout flag
interface mste_speed_seq_if;
    logic req_16mhz;
    logic req_cache;
    logic cpu_as_n;
    logic cache_flush_ack;
    logic cpu_clken;
    logic speed_16;
    logic cache_en;
    logic cache_flush;
    logic cpu_hold;
    logic flush_timeout;

    modport master (
        input  req_16mhz,
        input  req_cache,
        input  cpu_as_n,
        input  cache_flush_ack,
        output cpu_clken,
        output speed_16,
        output cache_en,
        output cache_flush,
        output cpu_hold,
        output flush_timeout
    );

    modport slave (
        output req_16mhz,
        output req_cache,
        output cpu_as_n,
        output cache_flush_ack,
        input  cpu_clken,
        input  speed_16,
        input  cache_en,
        input  cache_flush,
        input  cpu_hold,
        input  flush_timeout
    );
endinterface

// File: rtl/mste_speed_seq.sv
// Mega STE CPU speed / cache-enable change sequencer.
//
// Produces the CPU clock-enable pulse train (8 or 16 MHz from a 32 MHz clk) and
// applies speed and cache-enable changes requested by the config register only
// at a bus-idle phase boundary, flushing the cache first when the change needs it.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      mste_speed_seq_if.master: requests, bus status, flush handshake,
//            clock-enable and status outputs (all outputs registered)
module mste_speed_seq #(
    parameter int unsigned DIV_8         = 4,
    parameter int unsigned DIV_16        = 2,
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mste_speed_seq_if.master       bus
);

    localparam int unsigned DivMax = (DIV_8 > DIV_16) ? DIV_8 : DIV_16;
    localparam int unsigned CntW   = (DivMax > 1) ? $clog2(DivMax) : 1;
    localparam int unsigned ToW    = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

    localparam logic [CntW-1:0] DivLast8  = CntW'(DIV_8 - 1);
    localparam logic [CntW-1:0] DivLast16 = CntW'(DIV_16 - 1);
    localparam logic [ToW-1:0]  ToLast    = ToW'(FLUSH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun,
        StWaitBus,
        StFlush,
        StSwitch
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            cpu_clken_q, cpu_clken_d;
    logic            speed_16_q, speed_16_d;
    logic            cache_en_q, cache_en_d;
    logic            cache_flush_q, cache_flush_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            flush_timeout_q, flush_timeout_d;
    logic            s16_q, s16_d;
    logic            scache_q, scache_d;

    logic [CntW-1:0] div_last;
    logic            div_wrap;
    logic            change;
    logic            need_flush;

    always_comb begin
        div_last = speed_16_q ? DivLast16 : DivLast8;
        div_wrap = (div_cnt_q == div_last);
        change   = (bus.req_16mhz != speed_16_q) | (bus.req_cache != cache_en_q);
        // Evaluated on the live requests, which are exactly what gets snapshotted.
        need_flush = (bus.req_cache & ~cache_en_q)
                   | (cache_en_q & (bus.req_16mhz != speed_16_q));

        state_d         = state_q;
        div_cnt_d       = div_cnt_q;
        to_cnt_d        = to_cnt_q;
        cpu_clken_d     = 1'b0;
        speed_16_d      = speed_16_q;
        cache_en_d      = cache_en_q;
        cache_flush_d   = cache_flush_q;
        cpu_hold_d      = 1'b0;
        flush_timeout_d = flush_timeout_q;
        s16_d           = s16_q;
        scache_d        = scache_q;

        case (state_q)
            StRun: begin
                cpu_clken_d = div_wrap;
                div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
                if (change) begin
                    state_d = StWaitBus;
                end
            end

            StWaitBus: begin
                if (bus.cpu_as_n && div_wrap) begin
                    // Freeze the CPU at the phase boundary; the pulse that would
                    // have followed this wrap is suppressed because hold wins.
                    s16_d      = bus.req_16mhz;
                    scache_d   = bus.req_cache;
                    div_cnt_d  = '0;
                    to_cnt_d   = '0;
                    cpu_hold_d = 1'b1;
                    if (need_flush) begin
                        cache_flush_d = 1'b1;
                        state_d       = StFlush;
                    end else begin
                        state_d = StSwitch;
                    end
                end else begin
                    cpu_clken_d = div_wrap;
                    div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
                end
            end

            StFlush: begin
                cpu_hold_d = 1'b1;
                div_cnt_d  = '0;
                // Ack has priority over a simultaneous timeout.
                if (bus.cache_flush_ack) begin
                    cache_flush_d = 1'b0;
                    state_d       = StSwitch;
                end else if (to_cnt_q == ToLast) begin
                    flush_timeout_d = 1'b1;
                    cache_flush_d   = 1'b0;
                    state_d         = StSwitch;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            StSwitch: begin
                // Hold stays registered high through the first RUN cycle.
                cpu_hold_d = 1'b1;
                speed_16_d = s16_q;
                cache_en_d = scache_q;
                div_cnt_d  = '0;
                state_d    = StRun;
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StRun;
            div_cnt_q       <= '0;
            to_cnt_q        <= '0;
            cpu_clken_q     <= 1'b0;
            speed_16_q      <= 1'b0;
            cache_en_q      <= 1'b0;
            cache_flush_q   <= 1'b0;
            cpu_hold_q      <= 1'b0;
            flush_timeout_q <= 1'b0;
            s16_q           <= 1'b0;
            scache_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            div_cnt_q       <= div_cnt_d;
            to_cnt_q        <= to_cnt_d;
            cpu_clken_q     <= cpu_clken_d;
            speed_16_q      <= speed_16_d;
            cache_en_q      <= cache_en_d;
            cache_flush_q   <= cache_flush_d;
            cpu_hold_q      <= cpu_hold_d;
            flush_timeout_q <= flush_timeout_d;
            s16_q           <= s16_d;
            scache_q        <= scache_d;
        end
    end

    assign bus.cpu_clken     = cpu_clken_q;
    assign bus.speed_16      = speed_16_q;
    assign bus.cache_en      = cache_en_q;
    assign bus.cache_flush   = cache_flush_q;
    assign bus.cpu_hold      = cpu_hold_q;
    assign bus.flush_timeout = flush_timeout_q;

endmodule

// File: tb/tb_mste_speed_seq.sv
// Testbench for mste_speed_seq: directed scenarios, a cycle-level behavioural
// model compared against every output on each falling edge, and literal checks
// on pulse spacing, hold length and flush length.
module tb_mste_speed_seq;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    mste_speed_seq_if bus_if ();

    mste_speed_seq #(
        .DIV_8        (4),
        .DIV_16       (2),
        .FLUSH_TIMEOUT(64)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MIdle = 0, MPend = 1, MFlush = 2, MApply = 3;

    bit m_clken, m_speed, m_cache, m_flush, m_hold, m_to, m_s16, m_sc;
    int m_phase, m_mode, m_tcnt;

    task automatic model_reset();
        m_clken = 0; m_speed = 0; m_cache = 0; m_flush = 0; m_hold = 0; m_to = 0;
        m_s16 = 0; m_sc = 0; m_phase = 0; m_mode = MIdle; m_tcnt = 0;
    endtask

    task automatic model_step();
        int  period;
        bit  at_end, need, pulse;
        period = m_speed ? 2 : 4;
        at_end = (m_phase == period - 1);
        pulse  = 0;
        case (m_mode)
            MIdle, MPend: begin
                if (m_mode == MPend && bus_if.cpu_as_n && at_end) begin
                    m_s16  = bus_if.req_16mhz;
                    m_sc   = bus_if.req_cache;
                    need   = (m_sc && !m_cache) || (m_cache && (m_s16 != m_speed));
                    m_phase = 0;
                    m_hold  = 1;
                    m_flush = need;
                    m_tcnt  = 0;
                    m_mode  = need ? MFlush : MApply;
                end else begin
                    pulse   = at_end;
                    m_phase = at_end ? 0 : m_phase + 1;
                    m_hold  = 0;
                    if (m_mode == MIdle &&
                        (bus_if.req_16mhz != m_speed || bus_if.req_cache != m_cache))
                        m_mode = MPend;
                end
            end
            MFlush: begin
                if (bus_if.cache_flush_ack) begin
                    m_flush = 0; m_mode = MApply;
                end else if (m_tcnt == 63) begin
                    m_to = 1; m_flush = 0; m_mode = MApply;
                end else begin
                    m_tcnt++;
                end
            end
            default: begin
                m_speed = m_s16; m_cache = m_sc; m_phase = 0; m_mode = MIdle;
            end
        endcase
        m_clken = pulse;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("cmp_cpu_clken", bus_if.cpu_clken, m_clken);
                check("cmp_speed_16", bus_if.speed_16, m_speed);
                check("cmp_cache_en", bus_if.cache_en, m_cache);
                check("cmp_cache_flush", bus_if.cache_flush, m_flush);
                check("cmp_cpu_hold", bus_if.cpu_hold, m_hold);
                check("cmp_flush_timeout", bus_if.flush_timeout, m_to);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus_if.cpu_clken;
            1:       return bus_if.cpu_hold;
            default: return bus_if.cache_flush;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int sel, input logic val, input int budget);
        int n = 0;
        while (sig(sel) !== val && n < budget) begin
            step(1);
            n++;
        end
        check(name, sig(sel), val);
    endtask

    task automatic pulse_gap(input string name, input int exp);
        int n = 0;
        while (bus_if.cpu_clken !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        step(1);
        n = 1;
        while (bus_if.cpu_clken !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check(name, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int hc, fc;
        bus_if.req_16mhz       = 1'b0;
        bus_if.req_cache       = 1'b0;
        bus_if.cpu_as_n        = 1'b1;
        bus_if.cache_flush_ack = 1'b0;
        #1;
        reset_n  = 1'b0;
        model_on = 1'b1;
        step(3);
        check("rst_speed_16", bus_if.speed_16, 0);
        check("rst_cache_en", bus_if.cache_en, 0);
        check("rst_cpu_clken", bus_if.cpu_clken, 0);
        check("rst_cpu_hold", bus_if.cpu_hold, 0);
        check("rst_cache_flush", bus_if.cache_flush, 0);
        check("rst_flush_timeout", bus_if.flush_timeout, 0);
        reset_n = 1'b1;

        // 1: idle 8 MHz pulse train
        step(6);
        pulse_gap("t1_gap_8mhz", 4);
        check("t1_speed_16", bus_if.speed_16, 0);

        // 2: switch to 16 MHz, no flush
        bus_if.req_16mhz = 1'b1;
        hc = 0; fc = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            hc += int'(bus_if.cpu_hold);
            fc += int'(bus_if.cache_flush);
        end
        check("t2_hold_cycles", hc, 2);
        check("t2_flush_cycles", fc, 0);
        check("t2_speed_16", bus_if.speed_16, 1);
        pulse_gap("t2_gap_16mhz", 2);

        // 3: cache enable with busy bus, then acked flush
        bus_if.cpu_as_n  = 1'b0;
        bus_if.req_cache = 1'b1;
        hc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            hc += int'(bus_if.cpu_hold);
        end
        check("t3_no_hold_bus_busy", hc, 0);
        bus_if.cpu_as_n = 1'b1;
        wait_sig("t3_flush_up", 2, 1'b1, 10);
        step(4);
        bus_if.cache_flush_ack = 1'b1;
        wait_sig("t3_flush_down", 2, 1'b0, 10);
        bus_if.cache_flush_ack = 1'b0;
        wait_sig("t3_hold_down", 1, 1'b0, 10);
        check("t3_cache_en", bus_if.cache_en, 1);
        check("t3_flush_timeout", bus_if.flush_timeout, 0);
        pulse_gap("t3_gap_16mhz", 2);

        // 4: speed change with cache on, ack never arrives
        bus_if.req_16mhz = 1'b0;
        fc = 0;
        for (int i = 0; i < 150; i++) begin
            step(1);
            fc += int'(bus_if.cache_flush);
        end
        check("t4_flush_cycles", fc, 64);
        check("t4_flush_timeout", bus_if.flush_timeout, 1);
        check("t4_speed_16", bus_if.speed_16, 0);
        check("t4_cache_en", bus_if.cache_en, 1);
        pulse_gap("t4_gap_8mhz", 4);

        // 5: reset in the middle of a flush
        bus_if.req_16mhz = 1'b1;
        wait_sig("t5_flush_up", 2, 1'b1, 20);
        step(3);
        reset_n = 1'b0;
        #1;
        check("t5_cache_flush", bus_if.cache_flush, 0);
        check("t5_cpu_hold", bus_if.cpu_hold, 0);
        check("t5_speed_16", bus_if.speed_16, 0);
        check("t5_cache_en", bus_if.cache_en, 0);
        check("t5_flush_timeout", bus_if.flush_timeout, 0);
        bus_if.req_16mhz = 1'b0;
        bus_if.req_cache = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(4);
        pulse_gap("t5_gap_8mhz", 4);
        check("t5_hold_after", bus_if.cpu_hold, 0);

        // 6: request reverts during flush -> two sequences
        bus_if.req_16mhz = 1'b1;
        bus_if.req_cache = 1'b1;
        wait_sig("t6_flush1_up", 2, 1'b1, 20);
        bus_if.req_16mhz = 1'b0;
        step(2);
        bus_if.cache_flush_ack = 1'b1;
        wait_sig("t6_flush1_down", 2, 1'b0, 10);
        bus_if.cache_flush_ack = 1'b0;
        wait_sig("t6_hold1_down", 1, 1'b0, 10);
        check("t6_speed_first", bus_if.speed_16, 1);
        check("t6_cache_first", bus_if.cache_en, 1);
        wait_sig("t6_flush2_up", 2, 1'b1, 20);
        step(2);
        bus_if.cache_flush_ack = 1'b1;
        wait_sig("t6_flush2_down", 2, 1'b0, 10);
        bus_if.cache_flush_ack = 1'b0;
        wait_sig("t6_hold2_down", 1, 1'b0, 10);
        check("t6_speed_second", bus_if.speed_16, 0);
        check("t6_cache_second", bus_if.cache_en, 1);
        pulse_gap("t6_gap_8mhz", 4);

        step(5);
        model_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mste_speed_seq.md
Name: mste_speed_seq

Overview:
- Sequences Mega STE CPU speed and cache-enable changes requested by the config register (16 MHz bit, cache bit).
- Generates the CPU clock-enable pulse train at 8 or 16 MHz from the system clock.
- Applies requested changes only at a CPU bus-idle phase boundary, after a cache flush handshake where one is required.
- Sits between the config register outputs and the CPU clock-enable and cache controller.

Parameters:
- DIV_8, 4, clk cycles per CPU clken pulse in 8 MHz mode (clk = 32 MHz).
- DIV_16, 2, clk cycles per CPU clken pulse in 16 MHz mode.
- FLUSH_TIMEOUT, 64, max clk cycles to wait for cache_flush_ack before proceeding.

Ports:
- clk  in  1  system clock, single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- req_16mhz  in  1  requested speed from config register (1 = 16 MHz).
- req_cache  in  1  requested cache enable from config register.
- cpu_as_n  in  1  CPU address strobe; high = bus idle.
- cache_flush_ack  in  1  cache controller flush complete (level).
- cpu_clken  out  1  one-clk CPU clock-enable pulse.
- speed_16  out  1  effective speed currently applied.
- cache_en  out  1  effective cache enable currently applied.
- cache_flush  out  1  flush request to the cache controller (level).
- cpu_hold  out  1  high while a change is in progress (CPU frozen).
- flush_timeout  out  1  sticky; set if a flush timed out.

Behaviour:
- Reset (async assert, sync deassert effect): state=RUN, div_cnt=0, and all outputs 0 (speed_16, cache_en, cpu_clken, cache_flush, cpu_hold, flush_timeout).
- DIV = speed_16 ? DIV_16 : DIV_8. Counter width is clog2(max(DIV_8, DIV_16)).
- div_cnt counts 0..DIV-1 and wraps; cpu_clken is registered, =1 for exactly the clk cycle after div_cnt==DIV-1, and never while cpu_hold=1.
- change = (req_16mhz != speed_16) | (req_cache != cache_en), evaluated only in RUN.
- RUN: steady pulse train. If change -> WAIT_BUS.
- WAIT_BUS: pulses continue. Exit when cpu_as_n==1 and div_cnt==DIV-1 in the same cycle. On exit:
  - snapshot req_16mhz into s16 and req_cache into scache;
  - assert cpu_hold and force div_cnt=0;
  - need_flush = (scache & ~cache_en) | (cache_en & (s16 != speed_16));
  - go to FLUSH if need_flush, else SWITCH.
- FLUSH: cache_flush=1 and a timeout counter runs from 0.
  - cache_flush_ack==1 -> drop cache_flush next cycle, go to SWITCH.
  - Counter reaches FLUSH_TIMEOUT-1 without ack -> set flush_timeout, drop cache_flush, go to SWITCH.
  - Ack and timeout in the same cycle: ack wins; flush_timeout is not set.
- SWITCH (one cycle): speed_16<=s16, cache_en<=scache, div_cnt<=0, then RUN. cpu_hold drops on entry to RUN.
  - First clken at the new rate occurs DIV_new cycles after the RUN entry cycle.
- Requests changing after the snapshot are ignored until RUN, then re-detected as a new change. A request reverting to current values while in WAIT_BUS still completes the sequence as a no-op, with no flush.
- cpu_as_n low indefinitely: remain in WAIT_BUS, no hold, no deadlock of the CPU.
- Reset mid-sequence: immediate return to reset values, including cache_flush=0 and cpu_hold=0.
- flush_timeout clears only on reset.

Test Plan:
1. Reset, then idle with req=0/0 -> cpu_clken pulses every 4 clk; speed_16=0, cache_en=0, no hold.
2. req_16mhz=1, cpu_as_n=1, req_cache=0 -> WAIT_BUS, then SWITCH with no flush; cpu_hold high 2 cycles; afterwards clken every 2 clk and speed_16=1.
3. req_cache=1, cpu_as_n held low 20 cycles then high -> no hold while low; cache_flush asserted; ack after 5 cycles -> cache_en=1, flush_timeout=0, pulse train resumes.
4. cache_en=1 and speed change with ack never asserted -> cache_flush high for exactly 64 cycles; flush_timeout=1; speed switches.
5. reset_n low during FLUSH -> cache_flush, cpu_hold, speed_16 and cache_en all 0 immediately; after release, 8 MHz pulse train.
6. req_16mhz toggled 1 then back to 0 while in FLUSH -> sequence applies s16=1, then RUN re-detects the change and performs a second switch back to 8 MHz.
